seg_capture: RTL and testbench

Seven-segment receiver that watches the time-multiplexed segment bus and digit-select lines driven to the board display. It decodes each stable segment pattern back into the 4-bit display code used by the display encoder, and stores one code per digit position. It reports a one-cycle pulse when every digit has been refreshed. It sits beside the display driver as a self-check and readback monitor.

---
 rtl/seg_capture.sv | 150 +++++++++++++++
 tb/tb_seg_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// seg_capture: readback monitor for a time-multiplexed seven-segment display.
// It watches the segment bus and the digit-select lines. Once a pattern has
// been stable for STABLE samples, it decodes the pattern back into the 4-bit
// display code and stores that code in the selected slot. It pulses
// frame_valid once every slot has been refreshed.
module seg_capture #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int unsigned CW         = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE - 1);
  localparam logic [3:0]    CODE_BLANK = 4'hB;
  localparam logic [3:0]    CODE_BAD   = 4'hF;

  // One bus sample: the digit selects plus the raw segment byte.
  typedef struct packed {
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;
  } sample_t;

  sample_t             cur_c;
  sample_t             s1;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   seen_nxt;
  logic [DIGITS-1:0]   seen_upd;
  logic [4*DIGITS-1:0] digits_nxt;
  logic [DIGITS-1:0]   dp_nxt;
  logic                fv_nxt;
  logic                err_nxt;
  logic                new_err;
  logic                commit_c;
  logic                sel_none_c;
  logic                sel_multi_c;
  logic [3:0]          code_c;

  // Map segments A..G (DP excluded) back to the encoder's 4-bit code.
  function automatic logic [3:0] decode(input logic [6:0] p);
    logic [3:0] c;
    case (p)
      7'h7E:   c = 4'h0;
      7'h30:   c = 4'h1;
      7'h6D:   c = 4'h2;
      7'h79:   c = 4'h3;
      7'h33:   c = 4'h4;
      7'h5B:   c = 4'h5;
      7'h5F:   c = 4'h6;
      7'h70:   c = 4'h7;
      7'h7F:   c = 4'h8;
      7'h73:   c = 4'h9;
      7'h01:   c = 4'hA;
      7'h00:   c = 4'hB;
      7'h0D:   c = 4'hC;
      default: c = 4'hF;
    endcase
    return c;
  endfunction

  // The current bus sample in the same layout as s1.
  always_comb begin
    cur_c     = '0;
    cur_c.sel = dig_sel;
    cur_c.seg = seg_in;
  end

  // Stability counter: it restarts on any change and saturates, so a run
  // crosses the commit value only once.
  always_comb begin
    cnt_nxt = cnt;
    if (cur_c != s1) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Commit qualification and classification of the stable sample.
  assign commit_c    = (cnt == CNT_COMMIT);
  assign code_c      = decode(s1.seg[7:1]);
  assign sel_none_c  = (s1.sel == '0);
  assign sel_multi_c = ((s1.sel & (s1.sel - DIGITS'(1))) != '0);

  // Slot write, frame tracking and sticky error for the committed sample.
  always_comb begin
    digits_nxt = digits_out;
    dp_nxt     = dp_out;
    seen_nxt   = seen;
    seen_upd   = seen | s1.sel;
    fv_nxt     = 1'b0;
    new_err    = 1'b0;
    if (commit_c && !sel_none_c) begin
      if (sel_multi_c) begin
        new_err = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (s1.sel[i]) begin
            digits_nxt[4*i +: 4] = code_c;
            dp_nxt[i]            = s1.seg[0];
          end
        end
        if (code_c == CODE_BAD) begin
          new_err = 1'b1;
        end
        if (seen_upd == '1) begin
          fv_nxt   = 1'b1;
          seen_nxt = '0;
        end else begin
          seen_nxt = seen_upd;
        end
      end
    end
    // A new error outranks a clear on the same edge.
    err_nxt = (err & ~err_clr) | new_err;
  end

  // State register for the sampler, the counter and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      cnt         <= '0;
      seen        <= '0;
      digits_out  <= {DIGITS{CODE_BLANK}};
      dp_out      <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      s1          <= cur_c;
      cnt         <= cnt_nxt;
      seen        <= seen_nxt;
      digits_out  <= digits_nxt;
      dp_out      <= dp_nxt;
      frame_valid <= fv_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture. A run-length reference model predicts the
// outputs at every edge. A monitor process compares those predictions
// against the DUT, and checks each frame_valid pulse against a frame queue.
module tb_seg_capture;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned STABLE = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          seg_in = 8'h00;
  logic [DIGITS-1:0]   dig_sel = '0;
  logic                err_clr = 1'b0;
  logic [4*DIGITS-1:0] digits_out;
  logic [DIGITS-1:0]   dp_out;
  logic                frame_valid;
  logic                err;

  seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .err_clr(err_clr), .digits_out(digits_out), .dp_out(dp_out),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dig;
    logic [7:0]  dp;
    logic        fv;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frm_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Full-byte forms (DP = 0) of the codes 0..C, indexed by code.
  logic [7:0] pat_tab [13] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE,
                               8'hE0, 8'hFE, 8'hE6, 8'h02, 8'h00, 8'h1A};

  // Reference state.
  logic [31:0] m_dig;
  logic [7:0]  m_dp;
  logic [7:0]  m_seen;
  logic        m_err;
  logic        m_fv;
  logic [15:0] run_val;
  int          run_len;

  function automatic logic [3:0] ref_decode(input logic [7:0] seg);
    for (int i = 0; i < 13; i++)
      if ((seg & 8'hFE) == pat_tab[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Apply the commit of a stable sample to the reference.
  task automatic ref_commit(input logic [15:0] v, inout logic new_err);
    logic [7:0] sel;
    logic [7:0] seg;
    logic [3:0] code;
    int         idx;
    sel = v[15:8];
    seg = v[7:0];
    if ($countones(sel) > 1) begin
      new_err = 1'b1;
    end else if ($countones(sel) == 1) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (sel[i]) idx = i;
      code = ref_decode(seg);
      m_dig[4*idx +: 4] = code;
      m_dp[idx] = seg[0];
      if (code == 4'hF) new_err = 1'b1;
      m_seen[idx] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_fv = 1'b1;
        m_seen = 8'h00;
        frm_q.push_back(m_dig);
      end
    end
  endtask

  // Advance the reference by one clock edge with the inputs sampled there.
  task automatic ref_edge(input logic [7:0] sel, input logic [7:0] seg,
                          input logic clr, input logic r);
    logic ne;
    exp_t e;
    ne = 1'b0;
    if (r) begin
      m_dig = 32'hBBBBBBBB; m_dp = 0; m_seen = 0; m_err = 0; m_fv = 0;
      run_val = 16'h0; run_len = 1;
    end else begin
      m_fv = 1'b0;
      // A run commits once it has lasted exactly STABLE samples.
      if (run_len == STABLE) ref_commit(run_val, ne);
      if ({sel, seg} == run_val) begin
        if (run_len <= STABLE) run_len++;
      end else begin
        run_val = {sel, seg};
        run_len = 1;
      end
      m_err = (m_err && !clr) || ne;
    end
    e.dig = m_dig; e.dp = m_dp; e.fv = m_fv; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] sel, input logic [7:0] seg,
                      input logic clr, input logic r);
    @(negedge clk);
    dig_sel = sel; seg_in = seg; err_clr = clr; rst = r;
    @(posedge clk);
    ref_edge(sel, seg, clr, r);
  endtask

  task automatic hold(input logic [7:0] sel, input logic [7:0] seg, input int n);
    for (int k = 0; k < n; k++) step(sel, seg, 1'b0, 1'b0);
  endtask

  // Monitor: compare each cycle's prediction, and check every frame pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("digits_out", digits_out, e.dig);
        chk("dp_out", 32'(dp_out), 32'(e.dp));
        chk("frame_valid", 32'(frame_valid), 32'(e.fv));
        chk("err", 32'(err), 32'(e.err));
      end
      if (frame_valid === 1'b1) begin
        if (frm_q.size() == 0) begin
          chk("unexpected_frame", 32'(frame_valid), 32'h0);
        end else begin
          chk("frame_digits", digits_out, frm_q.pop_front());
        end
      end
    end
  end

  logic [7:0] pats [8] = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE};

  initial begin
    logic [7:0] rs, rg;
    int         len, r;
    // Reset.
    step(8'h00, 8'h00, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    #1;
    chk("reset_digits", digits_out, 32'hBBBBBBBB);
    chk("reset_err", 32'(err), 32'h0);
    // Held too briefly, then held long enough.
    hold(8'h08, 8'hF2, 3);
    hold(8'h00, 8'h00, 6);
    #1;
    chk("short_hold_slot3", 32'(digits_out[15:12]), 32'hB);
    hold(8'h08, 8'hF2, 4);
    hold(8'h00, 8'h00, 5);
    #1;
    chk("hold_slot3", 32'(digits_out[15:12]), 32'h3);
    // Two full frames.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) hold(8'(1 << i), pats[i], 5);
      hold(8'h00, 8'h00, 5);
    end
    #1;
    chk("frame_digits_const", digits_out, 32'h87654321);
    // Special codes and DP.
    hold(8'h01, 8'hFD, 5);
    hold(8'h02, 8'h02, 5);
    hold(8'h04, 8'h1A, 5);
    hold(8'h08, 8'h00, 5);
    hold(8'h00, 8'h00, 5);
    #1;
    chk("special_low", 32'(digits_out[15:0]), 32'hBCA0);
    chk("dp0", 32'(dp_out[0]), 32'h1);
    // Errors.
    hold(8'h10, 8'h12, 5);
    #1;
    chk("bad_pattern_err", 32'(err), 32'h1);
    step(8'h10, 8'h12, 1'b1, 1'b0);
    hold(8'h00, 8'h00, 2);
    #1;
    chk("err_cleared", 32'(err), 32'h0);
    hold(8'h20, 8'h12, 4);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    #1;
    chk("err_wins_clear", 32'(err), 32'h1);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    hold(8'h03, 8'hF2, 5);
    hold(8'h00, 8'h00, 6);
    // Reset mid-run.
    for (int i = 0; i < 5; i++) hold(8'(1 << i), pats[i], 5);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    #1;
    chk("midrun_reset_digits", digits_out, 32'hBBBBBBBB);
    for (int i = 7; i >= 0; i--) hold(8'(1 << i), pats[i], 5);
    hold(8'h00, 8'h00, 5);
    // Randomized runs.
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12)      rs = 8'h00;
      else if (r < 20) rs = 8'($urandom);
      else             rs = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7)
        rg = pat_tab[$urandom_range(0, 12)] | 8'($urandom_range(0, 1));
      else
        rg = 8'($urandom);
      len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++)
        step(rs, rg, ($urandom_range(0, 9) == 0), 1'b0);
      if ($urandom_range(0, 99) == 0) step(8'h00, 8'h00, 1'b0, 1'b1);
    end
    step(8'h00, 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("frame_queue_drained", 32'(frm_q.size()), 32'h0);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
